// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT coefficient lane arbiter.
package ntt_pkg;

   localparam int NTT_N_REQ  = 6;
   localparam int NTT_DATA_W = 16;
   localparam int NTT_N      = 256;

   typedef logic [2:0] ntt_sel_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_GRANT
   } ntt_arb_state_t;

endpackage

// File: rtl/ntt_rr_pick.sv
// Rotate-priority picker: returns the first valid index strictly after ptr, wrapping at NTT_N_REQ.
module ntt_rr_pick
   import ntt_pkg::*;
(
   input  logic [NTT_N_REQ-1:0] valid,
   input  ntt_sel_t             ptr,
   output ntt_sel_t             idx,
   output logic                 any
);

   int cand;

   // Scan from farthest to nearest so the nearest valid index after ptr wins.
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = 0;
      for (int k = NTT_N_REQ; k >= 1; k--) begin
         cand = int'(ptr) + k;
         if (cand >= NTT_N_REQ) cand = cand - NTT_N_REQ;
         if (valid[ntt_sel_t'(cand)]) begin
            idx = ntt_sel_t'(cand);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ntt_lane_arbiter.sv
// Round-robin arbiter sharing one NTT coefficient lane between six requesters.
// Define NTT_ARB_BURST_EN to hold the grant for a whole burst (until last or MAX_BURST beats).
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  ARB_IDLE  | no grant; pick next requester after rr pointer
//  ARB_GRANT | mux_sel fixed on grantee; beats accepted when output free
module ntt_lane_arbiter
   import ntt_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NTT_N_REQ-1:0]            req_valid,
   input  logic [NTT_N_REQ*NTT_DATA_W-1:0] req_data,
   input  logic [NTT_N_REQ-1:0]            req_last,
   output logic [NTT_N_REQ-1:0]            req_ready,
   output ntt_sel_t                        mux_sel,
   output logic                            out_valid,
   output logic [NTT_DATA_W-1:0]           out_data,
   output ntt_sel_t                        out_src,
   output logic                            out_last,
   input  logic                            out_ready,
   output logic                            err_ovr
);

   localparam int MAX_BURST = NTT_N;

   ntt_arb_state_t        state, state_nxt;
   ntt_sel_t              rr_ptr;
   ntt_sel_t              pick_idx;
   logic                  pick_any;
   logic                  sel_valid;
   logic [NTT_DATA_W-1:0] sel_data;
   logic                  sel_last;
   logic                  grant_open;
   logic                  accept;
   logic                  release_g;

   ntt_rr_pick u_pick (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      sel_last  = 1'b0;
      for (int i = 0; i < NTT_N_REQ; i++) begin
         if (mux_sel == ntt_sel_t'(i)) begin
            sel_valid = req_valid[i];
            sel_data  = req_data[i*NTT_DATA_W +: NTT_DATA_W];
            sel_last  = req_last[i];
         end
      end
   end

   // Ready only when the output register is empty or draining this cycle.
   assign grant_open = (state == ARB_GRANT) && (!out_valid || out_ready);
   assign accept     = grant_open && sel_valid;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NTT_N_REQ; i++) begin
         req_ready[i] = grant_open && (mux_sel == ntt_sel_t'(i));
      end
   end

`ifdef NTT_ARB_BURST_EN
   logic [$clog2(MAX_BURST)-1:0] beat_cnt;
   logic                         cnt_max;

   assign cnt_max   = (beat_cnt == ($clog2(MAX_BURST))'(MAX_BURST - 1));
   assign release_g = accept && (sel_last || cnt_max);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         err_ovr  <= 1'b0;
      end else begin
         err_ovr <= accept && !sel_last && cnt_max;
         if (release_g)   beat_cnt <= '0;
         else if (accept) beat_cnt <= beat_cnt + 1'b1;
      end
   end
`else
   assign release_g = accept;
   assign err_ovr   = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE:  if (pick_any)  state_nxt = ARB_GRANT;
         ARB_GRANT: if (release_g) state_nxt = ARB_IDLE;
         default:   state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ARB_IDLE;
         rr_ptr    <= ntt_sel_t'(NTT_N_REQ - 1);
         mux_sel   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         out_last  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ARB_IDLE && pick_any) mux_sel <= pick_idx;
         if (release_g) rr_ptr <= mux_sel;
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= mux_sel;
            out_last  <= sel_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ntt_lane_arbiter.sv
// Scoreboard bench for ntt_lane_arbiter: queue-level round-robin model feeds expected beats to a monitor.
module tb_ntt_lane_arbiter;
   import ntt_pkg::*;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } beat_t;

   typedef struct packed {
      logic [2:0]  src;
      logic [15:0] data;
      logic        last;
   } exp_t;

   localparam int BUDGET = 3000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  req_valid;
   logic [95:0] req_data;
   logic [5:0]  req_last;
   logic [5:0]  req_ready;
   logic [2:0]  mux_sel;
   logic        out_valid;
   logic [15:0] out_data;
   logic [2:0]  out_src;
   logic        out_last;
   logic        out_ready;
   logic        err_ovr;

   ntt_lane_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .mux_sel   (mux_sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_last  (out_last),
      .out_ready (out_ready),
      .err_ovr   (err_ovr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0;
   int   fails  = 0;
   beat_t q[6][$];
   beat_t mq[6][$];
   exp_t  exp_q[$];
   int   m_ptr = 5;
   int   err_exp = 0;
   int   err_seen = 0;
   bit   mon_en = 1'b0;
   bit   gap_en = 1'b0;
   int   last_out_cyc = -1;
   int   first_out_cyc = -1;
   int   start_cyc = 0;
   bit   held = 1'b0;
   logic [19:0] held_beat = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, expv, cyc);
      end
   endtask

   // Reference: whole-queue round robin; burst mode drains a burst per grant, capped at NTT_N beats.
   task automatic build_expect();
      int    w;
      int    n;
      beat_t b;
      for (int i = 0; i < 6; i++) mq[i] = q[i];
      while (1) begin
         w = -1;
         for (int k = 1; k <= 6; k++) begin
            if (w < 0 && mq[(m_ptr + k) % 6].size() > 0) w = (m_ptr + k) % 6;
         end
         if (w < 0) break;
         n = 0;
`ifdef NTT_ARB_BURST_EN
         do begin
            b = mq[w].pop_front();
            n++;
            exp_q.push_back('{src: 3'(w), data: b.data, last: b.last});
         end while (!b.last && n < NTT_N && mq[w].size() > 0);
         if (!b.last && n == NTT_N) err_exp++;
`else
         b = mq[w].pop_front();
         exp_q.push_back('{src: 3'(w), data: b.data, last: b.last});
`endif
         m_ptr = w;
      end
   endtask

   task automatic drive_heads();
      for (int i = 0; i < 6; i++) begin
         if (q[i].size() > 0) begin
            req_valid[i]          = 1'b1;
            req_data[i*16 +: 16]  = q[i][0].data;
            req_last[i]           = q[i][0].last;
         end else begin
            req_valid[i]          = 1'b0;
            req_data[i*16 +: 16]  = 16'h0;
            req_last[i]           = 1'b0;
         end
      end
   endtask

   function automatic bit pending();
      bit p = (exp_q.size() > 0);
      for (int i = 0; i < 6; i++) if (q[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic run_scenario(input int ready_pct, input bit gap);
      int         n;
      logic [5:0] acc;
      build_expect();
      gap_en        = gap;
      last_out_cyc  = -1;
      first_out_cyc = -1;
      @(posedge clk); #1;
      drive_heads();
      out_ready = ($urandom_range(99) < ready_pct);
      start_cyc = cyc;
      n = 0;
      while (pending() && n < BUDGET) begin
         @(negedge clk);
         acc = req_valid & req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < 6; i++) if (acc[i]) void'(q[i].pop_front());
         drive_heads();
         out_ready = ($urandom_range(99) < ready_pct);
         n++;
      end
      chk("scenario_drained", 32'(pending()), 0);
      gap_en    = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
         if (held) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_beat", 32'({out_src, out_data, out_last}), 32'(held_beat));
         end
         if (out_valid && !out_ready) chk("stall_req_ready", 32'(req_ready), 0);
         if (err_ovr) err_seen++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_beat actual src=%0d data=%0h expected=none", out_src, out_data);
            end else begin
               e = exp_q.pop_front();
               chk("out_src", 32'(out_src), 32'(e.src));
               chk("out_data", 32'(out_data), 32'(e.data));
               chk("out_last", 32'(out_last), 32'(e.last));
            end
            if (gap_en && last_out_cyc >= 0) chk("beat_gap", 32'(cyc - last_out_cyc), 2);
            last_out_cyc = cyc;
            if (first_out_cyc < 0) first_out_cyc = cyc;
         end
         held      = out_valid && !out_ready;
         held_beat = {out_src, out_data, out_last};
      end
   end

   task automatic fill_random();
      for (int i = 0; i < 6; i++) begin
`ifdef NTT_ARB_BURST_EN
         int nb = $urandom_range(2);
         for (int b = 0; b < nb; b++) begin
            int len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++)
               q[i].push_back('{data: 16'($urandom), last: (j == len - 1)});
         end
`else
         int nb = $urandom_range(5);
         for (int j = 0; j < nb; j++)
            q[i].push_back('{data: 16'($urandom), last: 1'($urandom)});
`endif
      end
   endtask

   initial begin
      int nacc;
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_src", 32'(out_src), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_err_ovr", 32'(err_ovr), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_mux_sel", 32'(mux_sel), 0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      m_ptr     = 5;
      mon_en    = 1'b1;

      // single beat from requester 0: two-cycle latency
      q[0].push_back('{data: 16'h0D00, last: 1'b1});
      run_scenario(100, 1'b0);
      chk("t1_latency", 32'(first_out_cyc - start_cyc), 2);

`ifdef NTT_ARB_BURST_EN
      for (int j = 0; j < NTT_N; j++) q[1].push_back('{data: 16'($urandom), last: (j == NTT_N - 1)});
      q[3].push_back('{data: 16'h3333, last: 1'b1});
      run_scenario(100, 1'b0);
      for (int j = 0; j < NTT_N; j++) q[4].push_back('{data: 16'($urandom), last: 1'b0});
      run_scenario(80, 1'b0);
`endif

      // all six requesters, steady downstream: one beat every two cycles
      q[0].push_back('{data: 16'h1000, last: 1'b1});
      for (int i = 0; i < 6; i++) q[i].push_back('{data: 16'($urandom), last: 1'b1});
      run_scenario(100, 1'b1);

      // backpressure-heavy and randomized traffic
      for (int r = 0; r < 8; r++) begin
         fill_random();
         run_scenario((r == 0) ? 20 : int'($urandom_range(30, 100)), 1'b0);
      end

      chk("err_ovr_pulses", 32'(err_seen), 32'(err_exp));

      // reset during a grant at beat 10 of requester 0
      mon_en = 1'b0;
      @(negedge clk);
      req_valid = 6'b000001;
      req_data  = '0;
      req_data[15:0] = 16'($urandom);
      req_last  = '0;
      out_ready = 1'b1;
      nacc = 0;
      for (int n = 0; n < 100 && nacc < 10; n++) begin
         @(negedge clk);
         if (req_ready[0]) nacc++;
         if (nacc < 10) begin
            @(posedge clk); #1;
            req_data[15:0] = 16'($urandom);
         end
      end
      chk("rst_reach_beat10", 32'(nacc), 10);
      rst_n     = 1'b0;
      req_valid = 6'b000011;
      @(posedge clk); #1;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_req_ready", 32'(req_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_rr_winner", 32'(mux_sel), 0);
      chk("midrst_ready_req0", 32'(req_ready), 32'(6'b000001));
      req_valid = '0;
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
